// File: rtl/ldl_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ldl_fifo_pkg
//   Constants and types shared between the read-side and write-side FIFO
//   blocks.
//
//   LDL_FIFO_MEM_LAT : read latency of the backing RAM in cycles (registered
//                      read data, valid the cycle after the read enable).
//   ldl_fifo_occ_t   : width of the output-buffer occupancy count
//                      (out reg + skid reg + one in-flight RAM read, 0..3).
// ---------------------------------------------------------------------------
package ldl_fifo_pkg;

  localparam int unsigned LDL_FIFO_MEM_LAT = 1;

  typedef logic [1:0] ldl_fifo_occ_t;

endpackage

// File: rtl/ldl_fifo_ob2.sv
// ---------------------------------------------------------------------------
// ldl_fifo_ob2
//   Two-entry output buffer for the read-ahead (first-word-fall-through) read
//   side. RAM words arrive one cycle after their read enable. Each word lands
//   in the out reg when the out reg is free after this cycle's pop. Otherwise
//   it lands in the skid reg. On a pop, the skid word moves into the out reg
//   so that word order is preserved. The parent limits read issue so that
//   out + skid + in-flight never exceeds two entries after a pop. Because of
//   this limit the skid reg cannot overflow.
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset; drops buffered and in-flight
//              words
//   mr    in   RAM read enable issued this cycle; becomes the in-flight flag
//   re    in   consumer pop request; ignored while the buffer is empty
//   md    in   RAM read data, valid while the in-flight flag is set
//   rd    out  out reg contents (head word)
//   empty out  out reg holds no word
//   pop   out  a word is consumed this cycle (re & out valid)
//   occ   out  out valid + skid valid + in-flight, before this cycle's pop
// ---------------------------------------------------------------------------
module ldl_fifo_ob2
  import ldl_fifo_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mr,
  input  logic          re,
  input  logic [DW-1:0] md,
  output logic [DW-1:0] rd,
  output logic          empty,
  output logic          pop,
  output ldl_fifo_occ_t occ
);

  logic          ov_q, ov_d;
  logic          sv_q, sv_d;
  logic          pv_q;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;

  always_comb begin
    ov_d   = ov_q;
    sv_d   = sv_q;
    out_d  = out_q;
    skid_d = skid_q;
    pop    = re & ov_q;

    if (pop) begin
      if (sv_q) begin
        // The skid word moves to the head. The arriving word refills the skid.
        out_d = skid_q;
        if (pv_q) begin
          skid_d = md;
        end else begin
          sv_d = 1'b0;
        end
      end else if (pv_q) begin
        out_d = md;
      end else begin
        ov_d = 1'b0;
      end
    end else if (pv_q) begin
      // No pop happens this cycle. Head busy: park the word in the skid reg.
      // Head free: the word becomes the head.
      if (ov_q) begin
        skid_d = md;
        sv_d   = 1'b1;
      end else begin
        out_d = md;
        ov_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q   <= 1'b0;
      sv_q   <= 1'b0;
      pv_q   <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      ov_q   <= ov_d;
      sv_q   <= sv_d;
      pv_q   <= mr;
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign rd    = out_q;
  assign empty = ~ov_q;
  assign occ   = ldl_fifo_occ_t'({1'b0, ov_q}) + ldl_fifo_occ_t'({1'b0, sv_q})
               + ldl_fifo_occ_t'({1'b0, pv_q});

endmodule

// File: rtl/ldl_fifo_rs_fwft.sv
// ---------------------------------------------------------------------------
// ldl_fifo_rs_fwft
//   Read side of a pointer-based FIFO that sits in front of a synchronous RAM
//   with one cycle of read latency. The block owns the read pointer. It
//   compares the read pointer with the write pointer from the write side and
//   issues RAM reads.
//     AHEAD = 1 : first-word-fall-through. Words are prefetched into a
//                 2-entry output buffer. rd shows the head word whenever
//                 empty is low. Sustained re gives one word per cycle.
//     AHEAD = 0 : standard read. An accepted re issues the RAM read, and
//                 rd = md in the following cycle.
//
// Configuration
//   LDL_FIFO_RS_CNT_EN  defined   : rcnt = (w_pt - r_pt) + buffered words
//                       undefined : rcnt tied to zero, no count logic
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   re    in   consumer read/pop request; ignored while empty
//   empty out  no word available to the consumer
//   rd    out  read data to the consumer
//   ra    out  RAM read address (r_pt[AW-1:0])
//   mr    out  RAM read enable
//   md    in   RAM read data, valid the cycle after mr
//   w_pt  in   write pointer from the write side (AW+1 bits, wrap bit on top)
//   r_pt  out  read pointer to the write side
//   rcnt  out  occupancy seen by the consumer
// ---------------------------------------------------------------------------
module ldl_fifo_rs_fwft
  import ldl_fifo_pkg::*;
#(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned AHEAD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  output logic          empty,
  output logic [DW-1:0] rd,
  output logic [AW-1:0] ra,
  output logic          mr,
  input  logic [DW-1:0] md,
  input  logic [AW:0]   w_pt,
  output logic [AW:0]   r_pt,
  output logic [AW:0]   rcnt
);

  logic [AW:0] r_pt_q, r_pt_d;
  logic        mem_ne;

`ifdef LDL_FIFO_RS_CNT_EN
  ldl_fifo_occ_t buf_cnt;
`endif

  assign mem_ne = (r_pt_q != w_pt);

  generate
    if (AHEAD != 0) begin : g_ahead
      ldl_fifo_occ_t occ;
      ldl_fifo_occ_t occ_after;
      logic          pop;

      ldl_fifo_ob2 #(
        .DW (DW)
      ) u_ob2 (
        .clk   (clk),
        .rst   (rst),
        .mr    (mr),
        .re    (re),
        .md    (md),
        .rd    (rd),
        .empty (empty),
        .pop   (pop),
        .occ   (occ)
      );

      // Fetch only while out + skid + in-flight stays within two entries
      // after this cycle's pop. pop implies out valid, so no underflow.
      assign occ_after = occ - ldl_fifo_occ_t'({1'b0, pop});
      assign mr        = ~rst & mem_ne & (occ_after < 2'd2);

`ifdef LDL_FIFO_RS_CNT_EN
      assign buf_cnt = occ;
`endif
    end else begin : g_std
      assign mr    = ~rst & re & mem_ne;
      assign empty = ~mem_ne;
      assign rd    = md;

`ifdef LDL_FIFO_RS_CNT_EN
      assign buf_cnt = '0;
`endif
    end
  endgenerate

  always_comb begin
    r_pt_d = r_pt_q;
    if (mr) begin
      r_pt_d = r_pt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pt_q <= '0;
    end else begin
      r_pt_q <= r_pt_d;
    end
  end

  assign r_pt = r_pt_q;
  assign ra   = r_pt_q[AW-1:0];

`ifdef LDL_FIFO_RS_CNT_EN
  assign rcnt = (w_pt - r_pt_q) + {{(AW - 1){1'b0}}, buf_cnt};
`else
  assign rcnt = '0;
`endif

endmodule

// File: doc/ldl_fifo_rs_fwft.md
LDL_FIFO_RS_FWFT -- requirements
Module: LDL_fifo_rs_fwft

Interface
REQ-001 SHALL have parameter AW, default 8: RAM address width, depth 2^AW; AW >= 2.
REQ-002 SHALL have parameter DW, default 8: data width.
REQ-003 SHALL have parameter AHEAD, default 1: 1 = first-word-fall-through (read ahead), 0 = standard read.
REQ-004 SHALL have port clk, input, 1: clock; all logic is single-clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port re, input, 1: consumer read/pop request.
REQ-007 SHALL have port empty, output, 1: no word available to the consumer.
REQ-008 SHALL have port rd, output, DW: read data to consumer.
REQ-009 SHALL have port ra, output, AW: RAM read address = r_pt[AW-1:0].
REQ-010 SHALL have port mr, output, 1: RAM read enable.
REQ-011 SHALL have port md, input, DW: RAM read data, valid the cycle after mr (1-cycle synchronous RAM).
REQ-012 SHALL have port w_pt, input, AW+1: write pointer from the write-side block.
REQ-013 SHALL have port r_pt, output, AW+1: read pointer to the write-side block (drives its full).
REQ-014 SHALL have port rcnt, output, AW+1: occupancy visible to consumer.

Function
REQ-015 SHALL compute mem_ne = (r_pt != w_pt); r_pt increments by 1 modulo 2^(AW+1) on every cycle mr is high, wrapping naturally.
REQ-016 AHEAD=0: mr = re & mem_ne; empty = ~mem_ne; rd = md (data in cycle after accepted re); re while empty ignored.
REQ-017 AHEAD=1: SHALL keep a 2-entry output buffer (out reg, skid reg) with valid flags ov, sv, plus in-flight flag pv = mr registered.
REQ-018 AHEAD=1: empty = ~ov; rd = out reg contents; pop = re & ov; re while empty ignored, no state change.
REQ-019 AHEAD=1: mr = mem_ne & ((ov + sv + pv - pop) < 2); guarantees skid never overflows.
REQ-020 AHEAD=1: when pv, md SHALL load out reg if out reg is free after this cycle's pop, else skid reg.
REQ-021 AHEAD=1: on pop with sv, skid moves to out reg same edge; if pv also, md goes to skid; order preserved strictly.
REQ-022 AHEAD=1: sustained re with mem_ne SHALL give one word per cycle with no bubbles.
REQ-023 AHEAD=1 latency: w_pt becomes != r_pt in cycle N with buffer empty -> mr in N, empty low and rd valid in N+2.
REQ-024 rcnt = (w_pt - r_pt) + (AHEAD ? ov + sv + pv : 0), width AW+1; max 2^AW + 2.
REQ-025 Simultaneous w_pt change and pop SHALL be handled in the same cycle without loss or duplicate.

Reset
REQ-026 On rst: r_pt = 0, ov = sv = pv = 0, rd = 0 (AHEAD=1), empty = 1, mr = 0, rcnt = 0 when w_pt = 0.
REQ-027 rst mid-operation SHALL discard buffered and in-flight words; md arriving the cycle after rst is ignored.

Configuration
REQ-028 Macro LDL_FIFO_RS_CNT_EN: defined -> rcnt per REQ-024; undefined -> rcnt tied to 0 and its adder logic removed.

Structure
REQ-029 Package LDL_fifo_pkg SHALL hold constant LDL_FIFO_MEM_LAT = 1 and the buffer-occupancy width type shared with write side.
REQ-030 Sub-module LDL_fifo_ob2 SHALL implement the 2-entry output buffer (REQ-017..021); instantiated only under AHEAD=1 generate branch.

Verification (AW=4, DW=8, AHEAD=1 unless noted)
REQ-031 Reset, w_pt=0 -> empty=1, mr=0, r_pt=0, rcnt=0 for all cycles, re toggling has no effect.
REQ-032 w_pt 0->1 in cycle N, RAM[0]=0xA5 -> mr in N, empty=0 and rd=0xA5 in N+2, rcnt=1.
REQ-033 Fill 16 words (w_pt=0x10), re held high -> 16 consecutive words 0..15 in order, no bubbles, then empty=1, r_pt=0x10.
REQ-034 Consumer stalls with 5 words written -> mr stops after 2 fetches, r_pt=2, rcnt=5; re high then drains 5 in order.
REQ-035 Pointer wrap: start r_pt=w_pt=0x1E, write 4 -> r_pt wraps to 0x02, data order intact.
REQ-036 AHEAD=0: re in cycle N with 1 word -> mr in N, rd valid N+1; rst asserted with 3 words buffered (AHEAD=1) -> next cycle empty=1, r_pt=0.
